// File: rtl/puf_soc_meas_ctrl.sv
// puf_soc_meas_ctrl
//   Measurement sequencer for an RO-PUF. For each response bit it selects an
//   RO pair, snapshots both counters, gates them for WIN_CYCLES, waits
//   SETTLE_CYCLES, then compares the wrap-safe count deltas and stores the
//   result bit. The finished RESP_BITS word is offered on a valid/ready port.
//
//   Optional feature macro: PUF_SOC_MAJ_VOTE_EN
//     When defined, each bit is measured three times on the same pair and the
//     bit is the majority of (da > db). The tie counter counts a bit once if
//     any of its passes tied.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_start, i_pair_base    run request and first RO-pair index (IDLE only)
//   i_cnt_a, i_cnt_b        live counter values of instances A and B
//   o_cnt_en                counter gate, high only in GATE
//   o_pair_idx              RO-pair select (base + bit index)
//   o_busy                  high whenever not IDLE
//   o_resp, o_resp_valid,
//   i_resp_ready            response word handshake
//   o_tie_cnt               bits decided by a tie, saturating at 255
module puf_soc_meas_ctrl #(
  parameter int unsigned CNT_BIT_SIZE  = 32,
  parameter int unsigned RESP_BITS     = 16,
  parameter int unsigned PAIR_W        = 4,
  parameter int unsigned WIN_CYCLES    = 1024,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [PAIR_W-1:0]       i_pair_base,
  input  logic [CNT_BIT_SIZE-1:0] i_cnt_a,
  input  logic [CNT_BIT_SIZE-1:0] i_cnt_b,
  output logic                    o_cnt_en,
  output logic [PAIR_W-1:0]       o_pair_idx,
  output logic                    o_busy,
  output logic [RESP_BITS-1:0]    o_resp,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [7:0]              o_tie_cnt
);

  localparam int unsigned KW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned TMAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [KW-1:0] K_LAST      = KW'(RESP_BITS - 1);
  localparam logic [TW-1:0] WIN_LOAD    = TW'(WIN_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_GATE, S_SETTLE, S_EVAL, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [PAIR_W-1:0]       base_q, base_d;
  logic [KW-1:0]           k_q, k_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [CNT_BIT_SIZE-1:0] sa_q, sa_d, sb_q, sb_d;
  logic                    cnt_en_q, cnt_en_d;
  logic [PAIR_W-1:0]       pair_q, pair_d;
  logic                    busy_q, busy_d;
  logic [RESP_BITS-1:0]    resp_q, resp_d;
  logic                    valid_q, valid_d;
  logic [7:0]              tie_q, tie_d;
`ifdef PUF_SOC_MAJ_VOTE_EN
  logic [1:0]              pass_q, pass_d;
  logic [1:0]              votes_q, votes_d;
  logic                    tie_any_q, tie_any_d;
`endif

  logic [CNT_BIT_SIZE-1:0] da, db;
  logic                    gt, eq, bit_done, bit_v, tie_hit;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    k_d      = k_q;
    tmr_d    = tmr_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_en_d = cnt_en_q;
    pair_d   = pair_q;
    resp_d   = resp_q;
    valid_d  = valid_q;
    tie_d    = tie_q;
`ifdef PUF_SOC_MAJ_VOTE_EN
    pass_d    = pass_q;
    votes_d   = votes_q;
    tie_any_d = tie_any_q;
`endif
    // Unsigned subtraction modulo 2^CNT_BIT_SIZE tolerates counter wrap.
    da       = i_cnt_a - sa_q;
    db       = i_cnt_b - sb_q;
    gt       = (da > db);
    eq       = (da == db);
    bit_done = 1'b0;
    bit_v    = 1'b0;
    tie_hit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d  = i_pair_base;
          k_d     = '0;
          resp_d  = '0;
          tie_d   = '0;
          pair_d  = i_pair_base;
          state_d = S_SNAP;
`ifdef PUF_SOC_MAJ_VOTE_EN
          pass_d    = '0;
          votes_d   = '0;
          tie_any_d = 1'b0;
`endif
        end
      end
      S_SNAP: begin
        sa_d     = i_cnt_a;
        sb_d     = i_cnt_b;
        tmr_d    = WIN_LOAD;
        cnt_en_d = 1'b1;
        state_d  = S_GATE;
      end
      S_GATE: begin
        if (tmr_q == '0) begin
          cnt_en_d = 1'b0;
          tmr_d    = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) state_d = S_EVAL;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_EVAL: begin
`ifdef PUF_SOC_MAJ_VOTE_EN
        if (pass_q != 2'd2) begin
          // Another pass on the same pair; o_pair_idx is left unchanged.
          pass_d    = pass_q + 2'd1;
          votes_d   = votes_q + {1'b0, gt};
          tie_any_d = tie_any_q | eq;
          state_d   = S_SNAP;
        end else begin
          bit_done  = 1'b1;
          bit_v     = ((votes_q + {1'b0, gt}) >= 2'd2);
          tie_hit   = tie_any_q | eq;
          pass_d    = '0;
          votes_d   = '0;
          tie_any_d = 1'b0;
        end
`else
        bit_done = 1'b1;
        bit_v    = gt;
        tie_hit  = eq;
`endif
        if (bit_done) begin
          resp_d[k_q] = bit_v;
          if (tie_hit && (tie_q != 8'hFF)) tie_d = tie_q + 8'd1;
          if (k_q == K_LAST) begin
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            k_d     = k_q + KW'(1);
            pair_d  = base_q + PAIR_W'(k_d);
            state_d = S_SNAP;
          end
        end
      end
      S_DONE: begin
        if (i_resp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      k_q      <= '0;
      tmr_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_en_q <= 1'b0;
      pair_q   <= '0;
      busy_q   <= 1'b0;
      resp_q   <= '0;
      valid_q  <= 1'b0;
      tie_q    <= '0;
`ifdef PUF_SOC_MAJ_VOTE_EN
      pass_q    <= '0;
      votes_q   <= '0;
      tie_any_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      k_q      <= k_d;
      tmr_q    <= tmr_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_en_q <= cnt_en_d;
      pair_q   <= pair_d;
      busy_q   <= busy_d;
      resp_q   <= resp_d;
      valid_q  <= valid_d;
      tie_q    <= tie_d;
`ifdef PUF_SOC_MAJ_VOTE_EN
      pass_q    <= pass_d;
      votes_q   <= votes_d;
      tie_any_q <= tie_any_d;
`endif
    end
  end

  assign o_cnt_en     = cnt_en_q;
  assign o_pair_idx   = pair_q;
  assign o_busy       = busy_q;
  assign o_resp       = resp_q;
  assign o_resp_valid = valid_q;
  assign o_tie_cnt    = tie_q;

endmodule

// File: tb/tb_puf_soc_meas_ctrl.sv
// Scoreboard bench for puf_soc_meas_ctrl: a behavioural pair of counters
// advances by a per-pair delta over each gate window; expected pair indices
// and response words are queued at stimulus time and checked by a monitor.
module tb_puf_soc_meas_ctrl;

  localparam int unsigned CW  = 32;
  localparam int unsigned RB  = 4;
  localparam int unsigned PW  = 4;
  localparam int unsigned WIN = 8;
  localparam int unsigned SET = 4;
`ifdef PUF_SOC_MAJ_VOTE_EN
  localparam int unsigned NPASS = 3;
`else
  localparam int unsigned NPASS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic [PW-1:0] i_pair_base = '0;
  logic [CW-1:0] i_cnt_a, i_cnt_b;
  logic          o_cnt_en;
  logic [PW-1:0] o_pair_idx;
  logic          o_busy;
  logic [RB-1:0] o_resp;
  logic          o_resp_valid;
  logic          i_resp_ready = 1'b1;
  logic [7:0]    o_tie_cnt;

  always #5 clk = ~clk;

  puf_soc_meas_ctrl #(
    .CNT_BIT_SIZE(CW), .RESP_BITS(RB), .PAIR_W(PW),
    .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_pair_base(i_pair_base),
    .i_cnt_a(i_cnt_a), .i_cnt_b(i_cnt_b), .o_cnt_en(o_cnt_en),
    .o_pair_idx(o_pair_idx), .o_busy(o_busy), .o_resp(o_resp),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_tie_cnt(o_tie_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counter model: per-window delta per pair, spread over the window with
  // the remainder added on its first enabled cycle.
  int unsigned   da_tab[16];
  int unsigned   db_tab[16];
  logic [CW-1:0] cnt_a = '0, cnt_b = '0;
  logic [CW-1:0] preset_a = '0, preset_b = '0;
  logic          load_cnt = 1'b0;
  logic          en_prev_m = 1'b0;
  int unsigned   inc_a, inc_b;

  assign i_cnt_a = cnt_a;
  assign i_cnt_b = cnt_b;

  always @(posedge clk) begin
    if (load_cnt) begin
      cnt_a <= preset_a;
      cnt_b <= preset_b;
    end else if (o_cnt_en) begin
      inc_a = da_tab[int'(o_pair_idx)] / WIN + (en_prev_m ? 0 : da_tab[int'(o_pair_idx)] % WIN);
      inc_b = db_tab[int'(o_pair_idx)] / WIN + (en_prev_m ? 0 : db_tab[int'(o_pair_idx)] % WIN);
      cnt_a <= cnt_a + CW'(inc_a);
      cnt_b <= cnt_b + CW'(inc_b);
    end
    en_prev_m <= o_cnt_en;
  end

  typedef struct {
    logic [RB-1:0] resp;
    logic [7:0]    tie;
  } exp_t;

  logic [PW-1:0] exp_pair_q[$];
  exp_t          exp_resp_q[$];
  exp_t          e_cur;
  int            en_len = 0;
  logic          en_prev_mon = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      en_len      = 0;
      en_prev_mon = 1'b0;
      exp_pair_q.delete();
      exp_resp_q.delete();
    end else begin
      if (o_cnt_en) begin
        if (!en_prev_mon) begin
          if (exp_pair_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL pair_unexpected: gate opened on pair %0d, none expected", o_pair_idx);
          end else begin
            chk("pair_idx", 64'(o_pair_idx), 64'(exp_pair_q.pop_front()));
          end
        end
        en_len++;
      end else if (en_prev_mon) begin
        chk("gate_len", 64'(en_len), 64'(WIN));
        en_len = 0;
      end
      en_prev_mon = o_cnt_en;
      if (o_resp_valid && i_resp_ready) begin
        if (exp_resp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_unexpected: got 0x%0h, none expected", o_resp);
        end else begin
          e_cur = exp_resp_q.pop_front();
          chk("resp", 64'(o_resp), 64'(e_cur.resp));
          chk("tie_cnt", 64'(o_tie_cnt), 64'(e_cur.tie));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_tables();
    for (int i = 0; i < 16; i++) begin
      da_tab[i] = 50;
      db_tab[i] = 50;
    end
    da_tab[3]  = 80; db_tab[3]  = 40;
    da_tab[4]  = 30; db_tab[4]  = 70;
    da_tab[5]  = 64; db_tab[5]  = 16;
    da_tab[6]  = 8;  db_tab[6]  = 96;
    da_tab[14] = 90; db_tab[14] = 10;
    da_tab[0]  = 10; db_tab[0]  = 90;
    da_tab[1]  = 77; db_tab[1]  = 33;
  endtask

  task automatic set_all(input int unsigned a, input int unsigned b);
    for (int i = 0; i < 16; i++) begin
      da_tab[i] = a;
      db_tab[i] = b;
    end
  endtask

  task automatic push_run(input logic [PW-1:0] base, input logic [RB-1:0] resp,
                          input logic [7:0] tie, input bit with_resp);
    exp_t e;
    for (int k = 0; k < RB; k++)
      for (int p = 0; p < NPASS; p++)
        exp_pair_q.push_back(base + PW'(k));
    e.resp = resp;
    e.tie  = tie;
    if (with_resp) exp_resp_q.push_back(e);
  endtask

  task automatic start(input logic [PW-1:0] base);
    i_pair_base = base;
    i_start     = 1'b1;
    step();
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (o_resp_valid && i_resp_ready) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_timeout: no response handshake within 2000 cycles", name);
    end
    step();
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_cnt_en"}, 64'(o_cnt_en), 64'(0));
    chk({name, "_pair"},   64'(o_pair_idx), 64'(0));
    chk({name, "_busy"},   64'(o_busy), 64'(0));
    chk({name, "_resp"},   64'(o_resp), 64'(0));
    chk({name, "_valid"},  64'(o_resp_valid), 64'(0));
    chk({name, "_tie"},    64'(o_tie_cnt), 64'(0));
  endtask

  initial begin
    bit seen;
    init_tables();

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Basic run, with a start pulse while busy that must be ignored.
    push_run(4'd3, 4'b0101, 8'd0, 1'b1);
    start(4'd3);
    repeat (20) step();
    chk("busy_running", 64'(o_busy), 64'(1));
    i_pair_base = 4'd9;
    i_start     = 1'b1;
    step();
    i_start     = 1'b0;
    wait_done("basic");
    chk("after_basic_valid", 64'(o_resp_valid), 64'(0));
    chk("after_basic_busy", 64'(o_busy), 64'(0));
    repeat (3) step();
    chk("idle_resp_hold", 64'(o_resp), 64'(4'b0101));
    chk("idle_busy", 64'(o_busy), 64'(0));

    // Pair index wraps 14,15,0,1; pair 15 ties.
    push_run(4'd14, 4'b1001, 8'd1, 1'b1);
    start(4'd14);
    wait_done("pair_wrap");

    // All ties.
    set_all(100, 100);
    push_run(4'd7, 4'b0000, 8'd4, 1'b1);
    start(4'd7);
    wait_done("tie");

    // Counter wrap: A from FFFF_FFF0 by 32, B by 20 (also wrapping).
    set_all(32, 20);
    preset_a = 32'hFFFF_FFF0;
    preset_b = 32'hFFFF_FFFA;
    load_cnt = 1'b1;
    step();
    load_cnt = 1'b0;
    push_run(4'd0, 4'b1111, 8'd0, 1'b1);
    start(4'd0);
    wait_done("cnt_wrap");

    // Back-pressure: DONE held with ready low, start pulses ignored.
    init_tables();
    i_resp_ready = 1'b0;
    push_run(4'd3, 4'b0101, 8'd0, 1'b1);
    start(4'd3);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (o_resp_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL hold_timeout: o_resp_valid never rose");
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      i_start = (c == 4);
      chk("hold_valid", 64'(o_resp_valid), 64'(1));
      chk("hold_resp", 64'(o_resp), 64'(4'b0101));
    end
    i_start = 1'b0;
    @(posedge clk);
    #1;
    i_resp_ready = 1'b1;
    i_start      = 1'b1;
    i_pair_base  = 4'd5;
    step();
    i_start      = 1'b0;
    chk("hs_valid_drop", 64'(o_resp_valid), 64'(0));
    chk("hs_busy", 64'(o_busy), 64'(0));
    repeat (3) step();
    chk("hs_start_ignored_busy", 64'(o_busy), 64'(0));
    chk("hs_start_ignored_en", 64'(o_cnt_en), 64'(0));

    // Reset during GATE aborts the run.
    push_run(4'd3, 4'b0000, 8'd0, 1'b0);
    start(4'd3);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (o_cnt_en) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL abort_timeout: o_cnt_en never rose");
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("abort");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    repeat (3) step();
    chk("abort_stay_idle", 64'(o_busy), 64'(0));

    // Recovery run: pairs 5,6,7,8 -> 1,0,tie,tie.
    push_run(4'd5, 4'b0001, 8'd2, 1'b1);
    start(4'd5);
    wait_done("recover");
    repeat (2) step();
    chk("pairs_consumed", 64'(exp_pair_q.size()), 64'(0));
    chk("resps_consumed", 64'(exp_resp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
